// File: rtl/img_pkg.sv
// Shared pixel-format constants and helpers for the binary image pipeline.
// Used by both the RGB-to-binary converter and the grayscale-to-RGB expander.
package img_pkg;

  localparam int PIX_W = 8;
  localparam int SUM_W = 2 * PIX_W;

  localparam logic [PIX_W-1:0] BIN_ON    = 8'hFF;
  localparam logic [PIX_W-1:0] BIN_OFF   = 8'h00;
  localparam logic [PIX_W-1:0] THR_RESET = 8'h80;

  // Q0.8 luma weights; they sum to 256 so white maps to 255 after truncation.
  localparam int DEF_COEF_R = 77;
  localparam int DEF_COEF_G = 150;
  localparam int DEF_COEF_B = 29;

  localparam int DEF_IMG_W = 256;
  localparam int DEF_IMG_H = 256;

  typedef struct packed {
    logic sof;
    logic eol;
    logic eof;
  } tag_t;

  function automatic logic [PIX_W-1:0] binarise(input logic [PIX_W-1:0] luma,
                                                input logic [PIX_W-1:0] thr);
    return (luma > thr) ? BIN_ON : BIN_OFF;
  endfunction

endpackage

// File: rtl/raster_counter.sv
// Column/row position tracker producing start-of-frame, end-of-line and
// end-of-frame tags for the pixel currently presented at the stream input.
module raster_counter
  import img_pkg::*;
#(
  parameter int IMG_W = DEF_IMG_W,
  parameter int IMG_H = DEF_IMG_H,
  localparam int COL_W = (IMG_W > 1) ? $clog2(IMG_W) : 1,
  localparam int ROW_W = (IMG_H > 1) ? $clog2(IMG_H) : 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic step_i,
  output tag_t tag_o
);

  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - 1);

  logic [COL_W-1:0] col_q, col_d;
  logic [ROW_W-1:0] row_q, row_d;
  logic             colLast, rowLast;

  assign colLast = (col_q == COL_LAST);
  assign rowLast = (row_q == ROW_LAST);

  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (step_i) begin
      if (colLast) begin
        col_d = '0;
        row_d = rowLast ? '0 : row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_q <= '0;
      row_q <= '0;
    end else begin
      col_q <= col_d;
      row_q <= row_d;
    end
  end

  assign tag_o.sof = (col_q == '0) && (row_q == '0);
  assign tag_o.eol = colLast;
  assign tag_o.eof = colLast && rowLast;

endmodule

// File: rtl/rgb_to_binary.sv
// Streaming RGB -> luma + thresholded binary pixel converter with raster tags.
// Two-stage pipeline that only moves when the output slot is free or drained.
module rgb_to_binary
  import img_pkg::*;
#(
  parameter int IMG_W  = DEF_IMG_W,
  parameter int IMG_H  = DEF_IMG_H,
  parameter int COEF_R = DEF_COEF_R,
  parameter int COEF_G = DEF_COEF_G,
  parameter int COEF_B = DEF_COEF_B
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [PIX_W-1:0] in_r,
  input  logic [PIX_W-1:0] in_g,
  input  logic [PIX_W-1:0] in_b,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [PIX_W-1:0] threshold,
  output logic [PIX_W-1:0] out_gray,
  output logic [PIX_W-1:0] out_bin,
  output logic             out_sof,
  output logic             out_eol,
  output logic             out_eof,
  output logic             out_valid,
  input  logic             out_ready
);

  localparam logic [SUM_W-1:0] CR = SUM_W'(COEF_R);
  localparam logic [SUM_W-1:0] CG = SUM_W'(COEF_G);
  localparam logic [SUM_W-1:0] CB = SUM_W'(COEF_B);

  logic             advance;
  logic             inFire;
  tag_t             tagNow;
  logic [SUM_W-1:0] lumaSum_d;
  logic [PIX_W-1:0] luma_d;
  logic [PIX_W-1:0] thrUse_d;

  logic             s1Valid_q;
  logic [PIX_W-1:0] s1Luma_q;
  logic [PIX_W-1:0] s1Thr_q;
  tag_t             s1Tag_q;
  logic [PIX_W-1:0] thrLatched_q;

  logic             outValid_q;
  logic [PIX_W-1:0] outGray_q;
  logic [PIX_W-1:0] outBin_q;
  tag_t             outTag_q;

  assign advance  = !outValid_q || out_ready;
  assign in_ready = advance;
  assign inFire   = in_valid && advance;

  raster_counter #(
    .IMG_W(IMG_W),
    .IMG_H(IMG_H)
  ) u_raster (
    .clk   (clk),
    .rst_n (rst_n),
    .step_i(inFire),
    .tag_o (tagNow)
  );

  // The first pixel of a frame must already see the threshold it latches,
  // so the threshold travels with the pixel instead of being read at stage 2.
  always_comb begin
    lumaSum_d = CR * SUM_W'(in_r) + CG * SUM_W'(in_g) + CB * SUM_W'(in_b);
    luma_d    = PIX_W'(lumaSum_d >> PIX_W);
    thrUse_d  = tagNow.sof ? threshold : thrLatched_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1Valid_q    <= 1'b0;
      s1Luma_q     <= '0;
      s1Thr_q      <= '0;
      s1Tag_q      <= '0;
      thrLatched_q <= THR_RESET;
    end else if (advance) begin
      s1Valid_q <= inFire;
      if (inFire) begin
        s1Luma_q <= luma_d;
        s1Thr_q  <= thrUse_d;
        s1Tag_q  <= tagNow;
        if (tagNow.sof) begin
          thrLatched_q <= threshold;
        end
      end
    end
  end

  // Flags are forced low on bubbles so they are only ever seen with out_valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      outValid_q <= 1'b0;
      outGray_q  <= '0;
      outBin_q   <= '0;
      outTag_q   <= '0;
    end else if (advance) begin
      outValid_q <= s1Valid_q;
      outTag_q   <= s1Valid_q ? s1Tag_q : '0;
      if (s1Valid_q) begin
        outGray_q <= s1Luma_q;
        outBin_q  <= binarise(s1Luma_q, s1Thr_q);
      end
    end
  end

  assign out_valid = outValid_q;
  assign out_gray  = outGray_q;
  assign out_bin   = outBin_q;
  assign out_sof   = outTag_q.sof;
  assign out_eol   = outTag_q.eol;
  assign out_eof   = outTag_q.eof;

endmodule

// File: tb/tb_rgb_to_binary.sv
// Scoreboard bench for rgb_to_binary on a 4x2 frame: expected pixels are
// modelled when an input is accepted and compared when the output transfers.
module tb_rgb_to_binary;

  localparam int IMG_W = 4;
  localparam int IMG_H = 2;

  typedef struct packed {
    logic       present;
    logic [7:0] gray;
    logic [7:0] bin;
    logic       sof;
    logic       eol;
    logic       eof;
  } pix_t;

  logic       clk;
  logic       rst_n;
  logic [7:0] in_r, in_g, in_b;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] threshold;
  logic [7:0] out_gray, out_bin;
  logic       out_sof, out_eol, out_eof;
  logic       out_valid;
  logic       out_ready;

  int   testsRun    = 0;
  int   testsFailed = 0;
  pix_t scoreQ[$];
  int   modelCol, modelRow;
  logic [7:0] modelThr;

  rgb_to_binary #(
    .IMG_W(IMG_W),
    .IMG_H(IMG_H)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_r     (in_r),
    .in_g     (in_g),
    .in_b     (in_b),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .threshold(threshold),
    .out_gray (out_gray),
    .out_bin  (out_bin),
    .out_sof  (out_sof),
    .out_eol  (out_eol),
    .out_eof  (out_eof),
    .out_valid(out_valid),
    .out_ready(out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic resetModel();
    scoreQ.delete();
    modelCol = 0;
    modelRow = 0;
    modelThr = 8'h80;
  endtask

  // Drives one cycle starting at posedge+1, records handshakes, pushes the
  // modelled result of an accepted pixel and pops one on an output transfer.
  task automatic applyStimulus(input logic iv, input logic [7:0] r, g, b, thr,
                               input logic ordy, output logic acc,
                               output logic oFire, output pix_t obsPix,
                               output pix_t expPix);
    pix_t       e;
    int         sum;
    logic [7:0] gray;
    in_valid  = iv;
    in_r      = r;
    in_g      = g;
    in_b      = b;
    threshold = thr;
    out_ready = ordy;
    #1;
    acc   = in_valid & in_ready;
    oFire = out_valid & out_ready;
    obsPix.present = 1'b1;
    obsPix.gray    = out_gray;
    obsPix.bin     = out_bin;
    obsPix.sof     = out_sof;
    obsPix.eol     = out_eol;
    obsPix.eof     = out_eof;
    expPix = '0;
    if (oFire && scoreQ.size() > 0) expPix = scoreQ.pop_front();
    if (acc) begin
      if (modelRow == 0 && modelCol == 0) modelThr = thr;
      sum       = 77 * int'(r) + 150 * int'(g) + 29 * int'(b);
      gray      = 8'(sum >> 8);
      e.present = 1'b1;
      e.gray    = gray;
      e.bin     = (gray > modelThr) ? 8'hFF : 8'h00;
      e.sof     = (modelRow == 0 && modelCol == 0);
      e.eol     = (modelCol == IMG_W - 1);
      e.eof     = e.eol && (modelRow == IMG_H - 1);
      if (modelCol == IMG_W - 1) begin
        modelCol = 0;
        modelRow = (modelRow == IMG_H - 1) ? 0 : modelRow + 1;
      end else begin
        modelCol++;
      end
      scoreQ.push_back(e);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    rst_n     = 1'b0;
    #2;
    rst_n = 1'b1;
    resetModel();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    in_r = 8'h00; in_g = 8'h00; in_b = 8'h00;
    threshold = 8'h00;
    resetModel();
    #1;
    testsRun++;
    if (out_valid !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_out_valid: got %b, expected 0", out_valid); end
    testsRun++;
    if (in_ready !== 1'b1) begin testsFailed++; $display("[TB] FAIL reset_in_ready: got %b, expected 1", in_ready); end
    testsRun++;
    if (out_gray !== 8'h00) begin testsFailed++; $display("[TB] FAIL reset_out_gray: got %h, expected 00", out_gray); end
    testsRun++;
    if (out_bin !== 8'h00) begin testsFailed++; $display("[TB] FAIL reset_out_bin: got %h, expected 00", out_bin); end
    testsRun++;
    if ({out_sof, out_eol, out_eof} !== 3'b000) begin
      testsFailed++; $display("[TB] FAIL reset_flags: got %b, expected 000", {out_sof, out_eol, out_eof});
    end
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    testsRun++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      testsFailed++; $display("[TB] FAIL post_reset_idle: got valid=%b ready=%b, expected valid=0 ready=1", out_valid, in_ready);
    end
  endtask

  task automatic test_latency();
    logic acc, oFire;
    pix_t obsPix, expPix;
    int   lat;
    doReset();
    applyStimulus(1'b1, 8'd128, 8'd128, 8'd128, 8'd127, 1'b1, acc, oFire, obsPix, expPix);
    testsRun++;
    if (acc !== 1'b1) begin testsFailed++; $display("[TB] FAIL latency_accept: got %b, expected 1", acc); end
    lat = 1;
    while (out_valid !== 1'b1 && lat < 10) begin
      applyStimulus(1'b0, 8'd0, 8'd0, 8'd0, 8'd127, 1'b1, acc, oFire, obsPix, expPix);
      lat++;
    end
    testsRun++;
    if (lat != 2) begin testsFailed++; $display("[TB] FAIL latency_cycles: got %0d, expected 2", lat); end
    applyStimulus(1'b0, 8'd0, 8'd0, 8'd0, 8'd127, 1'b1, acc, oFire, obsPix, expPix);
    testsRun++;
    if (oFire !== 1'b1 || obsPix !== expPix) begin
      testsFailed++; $display("[TB] FAIL latency_pixel: got %h, expected %h", obsPix, expPix);
    end
    testsRun++;
    if (out_valid !== 1'b0) begin testsFailed++; $display("[TB] FAIL latency_drain: got valid=%b, expected 0", out_valid); end
  endtask

  task automatic test_gray_levels();
    logic [7:0] rs[8] = '{8'd128, 8'd255, 8'd0, 8'd255, 8'd255, 8'd0, 8'd255, 8'd128};
    logic [7:0] gs[8] = '{8'd128, 8'd255, 8'd0, 8'd0,   8'd0,   8'd0, 8'd255, 8'd128};
    logic [7:0] bs[8] = '{8'd128, 8'd255, 8'd0, 8'd0,   8'd0,   8'd0, 8'd255, 8'd128};
    logic acc, oFire;
    pix_t obsPix, expPix;
    int   sent = 0;
    int   got  = 0;
    doReset();
    for (int cyc = 0; cyc < 100 && (sent < 8 || scoreQ.size() > 0); cyc++) begin
      applyStimulus(sent < 8, rs[sent % 8], gs[sent % 8], bs[sent % 8], 8'd127, 1'b1,
                    acc, oFire, obsPix, expPix);
      if (acc) sent++;
      if (oFire) begin
        testsRun++;
        if (obsPix !== expPix) begin
          testsFailed++; $display("[TB] FAIL gray_levels #%0d: got %h, expected %h", got, obsPix, expPix);
        end
        got++;
      end
    end
    testsRun++;
    if (got != 8) begin testsFailed++; $display("[TB] FAIL gray_levels_count: got %0d, expected 8", got); end
  endtask

  task automatic test_strict_compare();
    logic acc, oFire;
    pix_t obsPix, expPix;
    int   sent = 0;
    int   got  = 0;
    logic [7:0] thr;
    doReset();
    for (int cyc = 0; cyc < 200 && (sent < 24 || scoreQ.size() > 0); cyc++) begin
      thr = (sent < 8) ? 8'd75 : (sent < 16) ? 8'd76 : 8'd127;
      applyStimulus(sent < 24, 8'd255, 8'd0, 8'd0, thr, 1'b1, acc, oFire, obsPix, expPix);
      if (acc) sent++;
      if (oFire) begin
        testsRun++;
        if (obsPix !== expPix) begin
          testsFailed++; $display("[TB] FAIL strict_compare #%0d: got %h, expected %h", got, obsPix, expPix);
        end
        got++;
      end
    end
    testsRun++;
    if (got != 24) begin testsFailed++; $display("[TB] FAIL strict_compare_count: got %0d, expected 24", got); end
  endtask

  task automatic test_raster_flags();
    logic acc, oFire;
    pix_t obsPix, expPix;
    int   sent = 0;
    int   got  = 0;
    int   sofPos = 0;
    int   eolCnt = 0;
    int   eofCnt = 0;
    doReset();
    for (int cyc = 0; cyc < 100 && (sent < 9 || scoreQ.size() > 0); cyc++) begin
      applyStimulus(sent < 9, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                    8'($urandom_range(0, 255)), 8'd100, 1'b1, acc, oFire, obsPix, expPix);
      if (acc) sent++;
      if (oFire) begin
        testsRun++;
        if (obsPix !== expPix) begin
          testsFailed++; $display("[TB] FAIL raster #%0d: got %h, expected %h", got, obsPix, expPix);
        end
        if (obsPix.sof) sofPos += (1 << got);
        if (obsPix.eol) eolCnt++;
        if (obsPix.eof) eofCnt++;
        got++;
      end
    end
    testsRun++;
    if (sofPos != ((1 << 0) | (1 << 8))) begin
      testsFailed++; $display("[TB] FAIL raster_sof_positions: got %h, expected %h", sofPos, 32'h101);
    end
    testsRun++;
    if (eolCnt != 2 || eofCnt != 1) begin
      testsFailed++; $display("[TB] FAIL raster_eol_eof_counts: got eol=%0d eof=%0d, expected eol=2 eof=1", eolCnt, eofCnt);
    end
  endtask

  task automatic test_back_to_back();
    logic acc, oFire, ordy;
    pix_t obsPix, expPix, snap;
    int   sent = 0;
    int   got  = 0;
    doReset();
    snap = '0;
    for (int cyc = 0; cyc < 200 && (sent < 16 || scoreQ.size() > 0); cyc++) begin
      ordy = !(cyc >= 6 && cyc < 9);
      applyStimulus(sent < 16, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                    8'($urandom_range(0, 255)), 8'd90, ordy, acc, oFire, obsPix, expPix);
      if (acc) sent++;
      if (!ordy) begin
        testsRun++;
        if (acc !== 1'b0) begin
          testsFailed++; $display("[TB] FAIL stall_in_ready cyc%0d: got accept=%b, expected 0", cyc, acc);
        end
        if (cyc == 6) snap = obsPix;
        else begin
          testsRun++;
          if (obsPix !== snap) begin
            testsFailed++; $display("[TB] FAIL stall_hold cyc%0d: got %h, expected %h", cyc, obsPix, snap);
          end
        end
      end
      if (oFire) begin
        testsRun++;
        if (obsPix !== expPix) begin
          testsFailed++; $display("[TB] FAIL back_to_back #%0d: got %h, expected %h", got, obsPix, expPix);
        end
        got++;
      end
    end
    testsRun++;
    if (got != 16) begin testsFailed++; $display("[TB] FAIL back_to_back_count: got %0d, expected 16", got); end
  endtask

  task automatic test_threshold_frame();
    logic acc, oFire;
    pix_t obsPix, expPix;
    int   sent = 0;
    int   got  = 0;
    int   onFrame1 = 0;
    int   onFrame2 = 0;
    doReset();
    for (int cyc = 0; cyc < 200 && (sent < 16 || scoreQ.size() > 0); cyc++) begin
      applyStimulus(sent < 16, 8'd100, 8'd100, 8'd100, (sent < 5) ? 8'd200 : 8'd10, 1'b1,
                    acc, oFire, obsPix, expPix);
      if (acc) sent++;
      if (oFire) begin
        testsRun++;
        if (obsPix !== expPix) begin
          testsFailed++; $display("[TB] FAIL threshold_frame #%0d: got %h, expected %h", got, obsPix, expPix);
        end
        if (obsPix.bin == 8'hFF) begin
          if (got < 8) onFrame1++;
          else onFrame2++;
        end
        got++;
      end
    end
    testsRun++;
    if (onFrame1 != 0 || onFrame2 != 8) begin
      testsFailed++; $display("[TB] FAIL threshold_frame_counts: got f1=%0d f2=%0d, expected f1=0 f2=8", onFrame1, onFrame2);
    end
  endtask

  task automatic test_reset_midframe();
    logic acc, oFire;
    pix_t obsPix, expPix;
    int   sent = 0;
    int   got  = 0;
    logic sawSof = 1'b0;
    doReset();
    for (int cyc = 0; cyc < 300 && sent < 100; cyc++) begin
      applyStimulus(1'b1, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                    8'($urandom_range(0, 255)), 8'd128, 1'b1, acc, oFire, obsPix, expPix);
      if (acc) sent++;
      if (oFire) begin
        testsRun++;
        if (obsPix !== expPix) begin
          testsFailed++; $display("[TB] FAIL pre_reset #%0d: got %h, expected %h", got, obsPix, expPix);
        end
        got++;
      end
    end
    in_valid = 1'b0;
    rst_n    = 1'b0;
    #1;
    testsRun++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_sof !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL async_reset: got valid=%b ready=%b sof=%b, expected valid=0 ready=1 sof=0",
               out_valid, in_ready, out_sof);
    end
    #1;
    rst_n = 1'b1;
    resetModel();
    @(posedge clk);
    #1;
    sent = 0;
    got  = 0;
    for (int cyc = 0; cyc < 20 && (sent < 1 || scoreQ.size() > 0); cyc++) begin
      applyStimulus(sent < 1, 8'd40, 8'd80, 8'd120, 8'd50, 1'b1, acc, oFire, obsPix, expPix);
      if (acc) sent++;
      if (oFire) begin
        testsRun++;
        if (obsPix !== expPix) begin
          testsFailed++; $display("[TB] FAIL post_reset_pixel: got %h, expected %h", obsPix, expPix);
        end
        sawSof = obsPix.sof;
        got++;
      end
    end
    testsRun++;
    if (got != 1 || sawSof !== 1'b1) begin
      testsFailed++; $display("[TB] FAIL post_reset_sof: got count=%0d sof=%b, expected count=1 sof=1", got, sawSof);
    end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_gray_levels();
    test_strict_compare();
    test_raster_flags();
    test_back_to_back();
    test_threshold_frame();
    test_reset_midframe();
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/rgb_to_binary.md
Name: rgb_to_binary

Overview:
- Streaming converter from RGB pixels to grayscale luma plus thresholded binary pixel; inverse path of the grayscale-to-RGB expander.
- Sits between the image source (camera/decoded frame stream) and the binary image processing pipeline.
- Tracks raster position and flags start/end of line and frame.
- Valid/ready handshake on both sides.

Parameters:
- IMG_W, 256, pixels per line (≥2)
- IMG_H, 256, lines per frame (≥2)
- COEF_R, 77, red luma weight (Q0.8)
- COEF_G, 150, green luma weight (Q0.8)
- COEF_B, 29, blue luma weight (Q0.8); COEF_R+COEF_G+COEF_B must equal 256

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- in_r  in  8  red channel
- in_g  in  8  green channel
- in_b  in  8  blue channel
- in_valid  in  1  input pixel valid
- in_ready  out  1  converter accepts pixel this cycle
- threshold  in  8  binarisation threshold, sampled per frame
- out_gray  out  8  luma pixel
- out_bin  out  8  binary pixel, 8'hFF or 8'h00
- out_sof  out  1  output pixel is row 0, col 0
- out_eol  out  1  output pixel is col IMG_W-1
- out_eof  out  1  output pixel is last of frame
- out_valid  out  1  output pixel valid
- out_ready  in  1  downstream accepts output

Behaviour:
- Reset (asynchronous, rst_n=0): every output 0 except in_ready; in_ready=1 after reset; counters row=col=0; pipeline valids cleared; latched threshold=8'h80.
- Transfer on in_valid&in_ready; output transfer on out_valid&out_ready.
- Two-stage pipeline; advance = !out_valid | out_ready; in_ready = advance (combinational).
- Stage 1 on advance: sum = COEF_R*R + COEF_G*G + COEF_B*B in 16 bits unsigned (max 65280, no overflow); luma = sum[15:8] (truncate, no rounding); carry row/col tags; s1_valid <= input transfer.
- Stage 2 on advance: out_gray <= luma; out_bin <= (luma > thr_latched) ? 8'hFF : 8'h00 (strictly greater); flags from tags; out_valid <= s1_valid.
- Latency: 2 cycles from input accept to out_valid with out_ready held high; throughput 1 pixel/cycle.
- Stall: out_valid & !out_ready holds all outputs and stage-1 contents stable; no pixel dropped or duplicated.
- Raster counters advance on input transfer only: col increments; at col=IMG_W-1 col wraps to 0 and row increments; at row=IMG_H-1 and col=IMG_W-1 both wrap to 0 (next pixel starts new frame).
- Threshold latched on input transfer of the row 0/col 0 pixel; that pixel and the rest of the frame use the new value; mid-frame changes ignored.
- out_sof, out_eol, out_eof valid only while out_valid; otherwise 0.
- IMG_W=1 or IMG_H=1 unsupported.
- Reset mid-frame: in-flight pixels discarded; next accepted pixel is row 0/col 0 with out_sof.

Decomposition:
- Shared package img_pkg: PIX_W=8, BIN_ON=8'hFF, BIN_OFF=8'h00, default luma coefficients, default IMG_W/IMG_H.
- One sub-module: raster_counter (col/row counters, sof/eol/eof tag generation, parameterised by IMG_W/IMG_H); reusable by the grayscale-to-RGB side.

Test Plan:
- R=G=B=128, threshold=127, out_ready=1 -> after 2 cycles out_gray=128, out_bin=FF; R=G=B=255 -> gray 255, bin FF; R=G=B=0 -> gray 0, bin 00.
- R=255,G=0,B=0, threshold=127 -> out_gray=76 (19635>>8), out_bin=00; threshold=75 -> out_bin=FF; threshold=76 -> 00 (strict compare).
- IMG_W=4, IMG_H=2, 8 back-to-back pixels -> sof on pixel 0, eol on pixels 3 and 7, eof on pixel 7 only; pixel 8 has sof again.
- out_ready low 3 cycles mid-stream with in_valid high -> in_ready low within the stall, outputs held stable, all 16 input pixels appear exactly once and in order.
- Threshold 200 at frame start, changed to 10 at pixel 5 -> whole frame binarised with 200; next frame uses 10.
- rst_n pulsed low mid-frame (pixel 100) -> out_valid=0 immediately (asynchronous), next accepted pixel emerges with out_sof=1.
